// File: rtl/pmp_checker_n.sv
// Multi-entry PMP checker: CSR-programmed cfg/addr pairs, OFF/TOR/NA4/NAPOT matching,
// two-stage valid/ready pipeline (S1 = per-entry hit/permit vectors, S2 = priority encode).
module pmp_checker_n #(
  parameter int NUM_ENTRIES = 8,
  parameter int ADDR_W      = 32,
  parameter int IDX_W       = (NUM_ENTRIES > 1) ? $clog2(NUM_ENTRIES) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              csr_we,
  input  logic              csr_sel,
  input  logic [IDX_W-1:0]  csr_idx,
  input  logic [ADDR_W-1:0] csr_wdata,
  output logic [ADDR_W-1:0] csr_rdata,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [1:0]        req_type,
  input  logic              req_mmode,
  output logic              resp_valid,
  input  logic              resp_ready,
  output logic              resp_allow,
  output logic              resp_matched,
  output logic [IDX_W-1:0]  resp_idx
);

  // Handshake: a transfer happens on an edge where valid && ready are both high;
  // valid and payload are held until that edge, ready never depends on valid.

  localparam logic [1:0] A_TOR   = 2'd1;
  localparam logic [1:0] A_NA4   = 2'd2;
  localparam logic [1:0] A_NAPOT = 2'd3;

  logic [7:0]             cfg     [NUM_ENTRIES];
  logic [ADDR_W-1:0]      pmpaddr [NUM_ENTRIES];
  logic [NUM_ENTRIES-1:0] addr_lock;
  logic [NUM_ENTRIES-1:0] hit;
  logic [NUM_ENTRIES-1:0] permit;
  logic [ADDR_W-1:0]      word_addr;
  logic [7:0]             wcfg;
  logic                   idx_ok;
  logic                   default_allow;

  assign word_addr     = req_addr >> 2;
  assign idx_ok        = (32'(csr_idx) < NUM_ENTRIES);
  assign default_allow = req_mmode && (req_type != 2'd3);
  // W without R is a reserved combination and is stored as W=0; bits 6:5 are hardwired 0.
  assign wcfg = {csr_wdata[7], 2'b00, csr_wdata[4:2], csr_wdata[1] & csr_wdata[0], csr_wdata[0]};

  for (genvar g = 0; g < NUM_ENTRIES; g++) begin : g_entry
    logic [ADDR_W-1:0] lo;
    logic [ADDR_W-1:0] mask;
    logic              perm_bit;

    if (g == 0) begin : g_lo0
      assign lo = '0;
    end else begin : g_lon
      assign lo = pmpaddr[g-1];
    end

    // A locked TOR entry also freezes the address register below it (its lower bound).
    if (g + 1 < NUM_ENTRIES) begin : g_lk
      assign addr_lock[g] = cfg[g][7] || (cfg[g+1][7] && (cfg[g+1][4:3] == A_TOR));
    end else begin : g_lk_last
      assign addr_lock[g] = cfg[g][7];
    end

    assign mask     = pmpaddr[g] ^ (pmpaddr[g] + ADDR_W'(1));
    assign perm_bit = cfg[g][req_type];

    assign hit[g] = (cfg[g][4:3] == A_TOR)   ? ((word_addr >= lo) && (word_addr < pmpaddr[g])) :
                    (cfg[g][4:3] == A_NA4)   ? (word_addr == pmpaddr[g]) :
                    (cfg[g][4:3] == A_NAPOT) ? ((word_addr & ~mask) == (pmpaddr[g] & ~mask)) :
                                               1'b0;

    assign permit[g] = (req_type != 2'd3) && ((req_mmode && !cfg[g][7]) || perm_bit);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        cfg[i]     <= '0;
        pmpaddr[i] <= '0;
      end
    end else if (csr_we && idx_ok) begin
      for (int i = 0; i < NUM_ENTRIES; i++) begin
        if (IDX_W'(i) == csr_idx) begin
          if (!csr_sel && !cfg[i][7]) cfg[i] <= wcfg;
          if (csr_sel && !addr_lock[i]) pmpaddr[i] <= csr_wdata;
        end
      end
    end
  end

  always_comb begin
    csr_rdata = '0;
    for (int i = 0; i < NUM_ENTRIES; i++) begin
      if (IDX_W'(i) == csr_idx) csr_rdata = csr_sel ? pmpaddr[i] : ADDR_W'(cfg[i]);
    end
  end

  logic                   s1_valid;
  logic [NUM_ENTRIES-1:0] s1_hit;
  logic [NUM_ENTRIES-1:0] s1_permit;
  logic                   s1_default;
  logic                   out_load;
  logic                   s1_advance;

  assign out_load   = !resp_valid || resp_ready;
  assign s1_advance = s1_valid && out_load;
  assign req_ready  = !s1_valid || s1_advance;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid   <= 1'b0;
      s1_hit     <= '0;
      s1_permit  <= '0;
      s1_default <= 1'b0;
    end else if (req_ready) begin
      s1_valid <= req_valid;
      if (req_valid) begin
        s1_hit     <= hit;
        s1_permit  <= permit;
        s1_default <= default_allow;
      end
    end
  end

  logic             enc_matched;
  logic             enc_allow;
  logic [IDX_W-1:0] enc_idx;

  // Scan from the top so the lowest-index hit is the last (winning) assignment.
  always_comb begin
    enc_matched = 1'b0;
    enc_allow   = s1_default;
    enc_idx     = '0;
    for (int i = NUM_ENTRIES - 1; i >= 0; i--) begin
      if (s1_hit[i]) begin
        enc_matched = 1'b1;
        enc_allow   = s1_permit[i];
        enc_idx     = IDX_W'(i);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      resp_valid   <= 1'b0;
      resp_allow   <= 1'b0;
      resp_matched <= 1'b0;
      resp_idx     <= '0;
    end else if (out_load) begin
      resp_valid <= s1_valid;
      if (s1_valid) begin
        resp_allow   <= enc_allow;
        resp_matched <= enc_matched;
        resp_idx     <= enc_idx;
      end
    end
  end

endmodule

// File: tb/tb_pmp_checker_n.sv
// Directed bench for pmp_checker_n: vector table of CSR writes/reads/requests/resets,
// plus hand sequences for backpressure, same-cycle CSR write, and mid-flight reset.
module tb_pmp_checker_n;

  localparam int N  = 8;
  localparam int AW = 32;
  localparam int IW = 3;

  logic          clk = 1'b0;
  logic          rst_n = 1'b0;
  logic          csr_we = 1'b0;
  logic          csr_sel = 1'b0;
  logic [IW-1:0] csr_idx = '0;
  logic [AW-1:0] csr_wdata = '0;
  logic [AW-1:0] csr_rdata;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [AW-1:0] req_addr = '0;
  logic [1:0]    req_type = '0;
  logic          req_mmode = 1'b0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic          resp_allow;
  logic          resp_matched;
  logic [IW-1:0] resp_idx;

  int n_vec  = 0;
  int n_fail = 0;

  pmp_checker_n #(.NUM_ENTRIES(N), .ADDR_W(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .csr_we(csr_we), .csr_sel(csr_sel), .csr_idx(csr_idx), .csr_wdata(csr_wdata),
    .csr_rdata(csr_rdata),
    .req_valid(req_valid), .req_ready(req_ready), .req_addr(req_addr),
    .req_type(req_type), .req_mmode(req_mmode),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_allow(resp_allow),
    .resp_matched(resp_matched), .resp_idx(resp_idx)
  );

  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  typedef struct {
    int            op;       // 0 csr write, 1 csr read check, 2 request, 3 reset
    logic          sel;
    logic [IW-1:0] idx;
    logic [AW-1:0] data;     // write data / expected read data / request address
    logic [1:0]    rtype;
    logic          mmode;
    logic          allow;
    logic          matched;
    logic [IW-1:0] ridx;
  } vec_t;

  vec_t vecs[$];
  logic [4:0] exp_q[$];

  function automatic vec_t w(logic s, logic [IW-1:0] i, logic [AW-1:0] d);
    vec_t v = '{op: 0, sel: s, idx: i, data: d, default: '0};
    return v;
  endfunction
  function automatic vec_t rd(logic s, logic [IW-1:0] i, logic [AW-1:0] d);
    vec_t v = '{op: 1, sel: s, idx: i, data: d, default: '0};
    return v;
  endfunction
  function automatic vec_t rq(logic [AW-1:0] a, logic [1:0] t, logic m,
                              logic al, logic ma, logic [IW-1:0] ix);
    vec_t v = '{op: 2, data: a, rtype: t, mmode: m, allow: al, matched: ma, ridx: ix,
                default: '0};
    return v;
  endfunction
  function automatic vec_t rs();
    vec_t v = '{op: 3, default: '0};
    return v;
  endfunction

  task automatic check(input string name, input logic [AW-1:0] act, input logic [AW-1:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // All driver tasks start and end at posedge+1.
  task automatic do_reset();
    rst_n = 1'b0;
    #1;
    check("reset resp_valid", AW'(resp_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
  endtask

  task automatic csr_write(input logic s, input logic [IW-1:0] i, input logic [AW-1:0] d);
    csr_we = 1'b1; csr_sel = s; csr_idx = i; csr_wdata = d;
    @(posedge clk); #1;
    csr_we = 1'b0;
  endtask

  task automatic csr_check(input string name, input logic s, input logic [IW-1:0] i,
                           input logic [AW-1:0] d);
    csr_sel = s; csr_idx = i;
    @(negedge clk);
    check(name, csr_rdata, d);
    @(posedge clk); #1;
  endtask

  task automatic accept_req(input string name, input logic [AW-1:0] a, input logic [1:0] t,
                            input logic m);
    int g = 0;
    req_valid = 1'b1; req_addr = a; req_type = t; req_mmode = m;
    @(negedge clk);
    while (!req_ready && g < 20) begin
      @(negedge clk);
      g++;
    end
    if (!req_ready) check({name, " ready timeout"}, AW'(req_ready), 1);
    @(posedge clk); #1;
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(input string name, input logic al, input logic ma,
                           input logic [IW-1:0] ix);
    int lat = 1;
    @(negedge clk);
    while (!resp_valid && lat < 10) begin
      @(negedge clk);
      lat++;
    end
    check({name, " latency"}, AW'(lat), 2);
    check({name, " allow"}, AW'(resp_allow), AW'(al));
    check({name, " matched"}, AW'(resp_matched), AW'(ma));
    check({name, " idx"}, AW'(resp_idx), AW'(ix));
    @(posedge clk); #1;
  endtask

  task automatic bp_driver();
    accept_req("bp A", 32'h1000, 2'd0, 1'b0);
    accept_req("bp B", 32'h1000, 2'd1, 1'b0);
    accept_req("bp C", 32'h2000, 2'd0, 1'b0);
    accept_req("bp D", 32'h2000, 2'd0, 1'b1);
  endtask

  task automatic bp_collector();
    int got = 0;
    for (int c = 0; c < 40 && got < 4; c++) begin
      @(negedge clk);
      if (resp_valid) begin
        if (exp_q.size() == 0) begin
          check("bp extra response", AW'(resp_valid), 0);
        end else begin
          check($sformatf("bp resp%0d", got), AW'({resp_allow, resp_matched, resp_idx}),
                AW'(exp_q[0]));
          if (resp_ready) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
    end
    check("bp responses received", AW'(got), 4);
  endtask

  task automatic bp_stall();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("bp req_ready stalled", AW'(req_ready), 0);
    check("bp resp_valid stalled", AW'(resp_valid), 1);
    @(posedge clk); #1;
    resp_ready = 1'b1;
  endtask

  initial begin
    vecs = '{
      rq(32'h1000, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0),
      rq(32'h1000, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0),
      rq(32'h1000, 2'd3, 1'b1, 1'b0, 1'b0, 3'd0),
      rd(1'b0, 3'd0, 32'h0),
      // NAPOT 4KB at 0x1000, R|X
      w(1'b1, 3'd0, 32'h5FF), w(1'b0, 3'd0, 32'h1D), rd(1'b0, 3'd0, 32'h1D),
      rq(32'h1FFC, 2'd0, 1'b0, 1'b1, 1'b1, 3'd0),
      rq(32'h1000, 2'd1, 1'b0, 1'b0, 1'b1, 3'd0),
      rq(32'h2000, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0),
      rq(32'h1000, 2'd2, 1'b0, 1'b1, 1'b1, 3'd0),
      rq(32'h1000, 2'd1, 1'b1, 1'b1, 1'b1, 3'd0),
      rq(32'h0FFC, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0),
      // TOR [0x2000, 0x3000) R|W in entry 1
      rs(), w(1'b1, 3'd0, 32'h800), w(1'b1, 3'd1, 32'hC00), w(1'b0, 3'd1, 32'h0B),
      rq(32'h2FFC, 2'd1, 1'b0, 1'b1, 1'b1, 3'd1),
      rq(32'h3000, 2'd1, 1'b0, 1'b0, 1'b0, 3'd0),
      rq(32'h2000, 2'd2, 1'b0, 1'b0, 1'b1, 3'd1),
      rq(32'h1FFC, 2'd0, 1'b0, 1'b0, 1'b0, 3'd0),
      w(1'b0, 3'd0, 32'h09),
      rq(32'h1000, 2'd0, 1'b0, 1'b1, 1'b1, 3'd0),
      rq(32'h2000, 2'd1, 1'b0, 1'b1, 1'b1, 3'd1),
      rq(32'h0000, 2'd1, 1'b0, 1'b0, 1'b1, 3'd0),
      // priority: NA4 R at 0x1000 beats NAPOT R|W
      rs(), w(1'b0, 3'd0, 32'h11), w(1'b1, 3'd0, 32'h400), w(1'b1, 3'd1, 32'h5FF),
      w(1'b0, 3'd1, 32'h1B),
      rq(32'h1000, 2'd1, 1'b0, 1'b0, 1'b1, 3'd0),
      rq(32'h1004, 2'd1, 1'b0, 1'b1, 1'b1, 3'd1),
      rq(32'h1000, 2'd0, 1'b0, 1'b1, 1'b1, 3'd0),
      // locks and reserved encodings
      rs(), w(1'b1, 3'd0, 32'h400), w(1'b0, 3'd0, 32'h91),
      rq(32'h1000, 2'd1, 1'b1, 1'b0, 1'b1, 3'd0),
      rq(32'h1000, 2'd0, 1'b1, 1'b1, 1'b1, 3'd0),
      w(1'b0, 3'd0, 32'h00), rd(1'b0, 3'd0, 32'h91),
      w(1'b1, 3'd0, 32'h123), rd(1'b1, 3'd0, 32'h400),
      w(1'b1, 3'd1, 32'h777), w(1'b0, 3'd2, 32'h88), rd(1'b0, 3'd2, 32'h88),
      w(1'b1, 3'd1, 32'h555), rd(1'b1, 3'd1, 32'h777),
      w(1'b0, 3'd3, 32'h02), rd(1'b0, 3'd3, 32'h00),
      w(1'b0, 3'd3, 32'h03), rd(1'b0, 3'd3, 32'h03),
      w(1'b0, 3'd5, 32'h90), rd(1'b0, 3'd5, 32'h90),
      w(1'b1, 3'd4, 32'h42), rd(1'b1, 3'd4, 32'h42),
      w(1'b0, 3'd6, 32'h61), rd(1'b0, 3'd6, 32'h01),
      rq(32'h0000, 2'd1, 1'b1, 1'b0, 1'b1, 3'd5),
      rq(32'h0008, 2'd0, 1'b1, 1'b1, 1'b0, 3'd0)
    };

    // clock/reset block
    repeat (2) @(posedge clk);
    #1;
    check("reset resp_valid", AW'(resp_valid), 0);
    check("reset req_ready", AW'(req_ready), 1);
    check("reset cfg0", csr_rdata, 0);
    rst_n = 1'b1;
    @(posedge clk); #1;

    foreach (vecs[i]) begin
      string nm = $sformatf("v%0d", i);
      case (vecs[i].op)
        0: csr_write(vecs[i].sel, vecs[i].idx, vecs[i].data);
        1: csr_check({nm, " csr_rdata"}, vecs[i].sel, vecs[i].idx, vecs[i].data);
        2: begin
          accept_req(nm, vecs[i].data, vecs[i].rtype, vecs[i].mmode);
          wait_resp(nm, vecs[i].allow, vecs[i].matched, vecs[i].ridx);
        end
        default: do_reset();
      endcase
    end

    // request and CSR write in the same cycle: request sees pre-write R|X
    do_reset();
    csr_write(1'b1, 3'd0, 32'h5FF);
    csr_write(1'b0, 3'd0, 32'h1D);
    csr_we = 1'b1; csr_sel = 1'b0; csr_idx = 3'd0; csr_wdata = 32'h18;
    accept_req("same-cycle", 32'h1000, 2'd0, 1'b0);
    csr_we = 1'b0;
    wait_resp("same-cycle", 1'b1, 1'b1, 3'd0);
    accept_req("after-write", 32'h1000, 2'd0, 1'b0);
    wait_resp("after-write", 1'b0, 1'b1, 3'd0);

    // reset while a request is in S1 discards it
    accept_req("mid-reset", 32'h1000, 2'd0, 1'b1);
    rst_n = 1'b0;
    #1;
    check("mid-reset resp_valid low", AW'(resp_valid), 0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    begin
      int seen = 0;
      repeat (4) begin
        @(negedge clk);
        if (resp_valid) seen++;
      end
      check("mid-reset no response", AW'(seen), 0);
      csr_check("mid-reset cfg0 cleared", 1'b0, 3'd0, 32'h0);
    end

    // backpressure: four back-to-back requests against a stalled consumer
    csr_write(1'b1, 3'd0, 32'h5FF);
    csr_write(1'b0, 3'd0, 32'h1D);
    exp_q.push_back(5'b11_000);
    exp_q.push_back(5'b01_000);
    exp_q.push_back(5'b00_000);
    exp_q.push_back(5'b10_000);
    resp_ready = 1'b0;
    fork
      bp_driver();
      bp_collector();
      bp_stall();
    join
    check("bp queue drained", AW'(exp_q.size()), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
    $finish;
  end

endmodule

// File: doc/pmp_checker_n.md
Name: pmp_checker_n

Overview:
- Multi-entry, pipelined physical-memory-protection checker.
- Holds NUM_ENTRIES pmpcfg/pmpaddr register pairs, written through a simple CSR port.
- Checks each access request against all entries (OFF/TOR/NA4/NAPOT) and returns allow/deny, lowest-index match wins.
- Sits between the core's LSU/fetch address path and the bus; replaces the single-entry combinational address checker.

Parameters:
- NUM_ENTRIES, 8, number of PMP entries (1..16).
- ADDR_W, 32, byte-address width; pmpaddr registers hold ADDR_W bits of word address (byte addr >> 2).
- IDX_W, $clog2(NUM_ENTRIES) (min 1), width of entry index fields.

Ports:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- csr_we  in  1  CSR write strobe.
- csr_sel  in  1  0 = pmpcfg[idx], 1 = pmpaddr[idx].
- csr_idx  in  IDX_W  entry index.
- csr_wdata  in  ADDR_W  write data (cfg uses bits 7:0).
- csr_rdata  out  ADDR_W  combinational readback of selected register (cfg zero-extended).
- req_valid  in  1  access request valid.
- req_ready  out  1  request accepted when valid&ready.
- req_addr  in  ADDR_W  byte address (word-granular check; uses req_addr>>2).
- req_type  in  2  0 = read, 1 = write, 2 = execute, 3 = reserved (always denied).
- req_mmode  in  1  1 = M-mode, 0 = U-mode.
- resp_valid  out  1  result valid.
- resp_ready  in  1  result consumed when valid&ready.
- resp_allow  out  1  access permitted.
- resp_matched  out  1  some entry matched.
- resp_idx  out  IDX_W  lowest matching entry (0 when no match).

Behaviour:
- Reset (async, rst_n=0): all pmpcfg=0, pmpaddr=0, pipeline valids=0, resp_valid/resp_allow/resp_matched/resp_idx=0. Reset mid-operation discards in-flight requests.
- pmpcfg layout: bit0 R, bit1 W, bit2 X, bits4:3 A (0 OFF, 1 TOR, 2 NA4, 3 NAPOT), bit7 L. Bits 6:5 read as 0.
- CSR write rules:
  - Write takes effect at the next edge; csr_idx >= NUM_ENTRIES writes are ignored and read as 0.
  - Write data with W=1, R=0 stores W=0.
  - Writes to cfg[i] or addr[i] are ignored when cfg[i].L=1.
  - Write to addr[i] is also ignored when cfg[i+1].L=1 and cfg[i+1].A=TOR.
  - L is cleared only by reset.
- Match for word address a = req_addr>>2:
  - OFF: never matches.
  - TOR: lo <= a < pmpaddr[i], where lo = pmpaddr[i-1], and lo = 0 for i=0. No match when lo >= pmpaddr[i].
  - NA4: a == pmpaddr[i].
  - NAPOT: mask = pmpaddr ^ (pmpaddr+1) covers the trailing ones plus the first zero; match when (a & ~mask) == (pmpaddr & ~mask). Region size = 2^(k+3) bytes for k trailing ones. All-ones pmpaddr matches the whole space.
- Permission:
  - Matched, with req_mmode=0 or L=1: allow = the R/W/X bit selected by req_type.
  - Matched, M-mode with L=0: allow = 1.
  - No match: allow = req_mmode.
  - req_type=3: allow = 0 always.
- Pipeline (2 stages, throughput 1/cycle):
  - S1 registers the per-entry match vector and per-entry permit vector, computed from CSR values at the acceptance edge. Later CSR writes do not affect in-flight requests. A request and a CSR write in the same cycle use pre-write values.
  - S2 priority-encodes into resp_*.
  - Latency: accepted at edge k, resp_valid=1 after edge k+1.
- Handshake and backpressure:
  - Output register loads when !resp_valid || resp_ready.
  - S1 advances when it is valid and the output register loads.
  - req_ready = !s1_valid || s1_advance.
  - resp_* hold stable while resp_valid && !resp_ready. No drop, no duplication, in-order.

Test Plan:
- Reset, all entries OFF: U read 0x1000 -> allow=0, matched=0. M read 0x1000 -> allow=1, matched=0.
- NAPOT: addr0=0x5FF, cfg0=0x1D (4KB at 0x1000, R|X). U read 0x1FFC -> allow=1, idx=0. U write 0x1000 -> allow=0. U read 0x2000 -> matched=0, allow=0.
- TOR: addr0=0x800, addr1=0xC00, cfg1=0x0B (TOR, R|W). U write 0x2FFC -> allow=1, idx=1. U write 0x3000 -> deny. U exec 0x2000 -> deny.
- Priority: cfg0=0x11 (NA4, R), addr0=0x400; entry1 NAPOT covering 0x1000 with R|W. U write 0x1000 -> allow=0, idx=0.
- Lock and reserved encodings:
  - cfg0=0x91, addr0=0x400: M write 0x1000 -> deny.
  - Write cfg0=0 -> reads 0x91; write addr0 -> unchanged.
  - cfg1=0x88 locks addr0.
  - Write cfg2=0x02 -> reads 0x00.
- Backpressure: 4 back-to-back requests with resp_ready=0 for 3 cycles -> req_ready=0 after 2 accepted, resp fields stable. All 4 responses then arrive in order with correct values. Latency 2 cycles when unstalled.
